pc_fetch_sequencer: RTL and testbench



---
 rtl/cpu31_pkg.sv | 21 ++
 rtl/pc_fetch_sequencer_pc_next_sel.sv | 41 ++++
 rtl/pc_fetch_sequencer.sv | 115 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu31_pkg.sv
// Shared types and constants for the CPU31 fetch/commit control path.
package cpu31_pkg;

    localparam logic [31:0] CPU31_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] CPU31_EXC_VECTOR = 32'h0040_0004;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NPC_EXC  = 2'd0,
        NPC_ERET = 2'd1,
        NPC_BR   = 2'd2,
        NPC_SEQ  = 2'd3
    } npc_sel_t;

endpackage

// File: rtl/pc_fetch_sequencer_pc_next_sel.sv
// Next-PC priority select: exception, eret, taken branch/jump, then PC+4.
module pc_next_sel
    import cpu31_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = CPU31_EXC_VECTOR
) (
    input  logic [31:0] pc_out,
    input  logic [31:0] epc,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic        br_taken,
    output logic [31:0] next_pc,
    output logic        epc_we
);

    npc_sel_t sel;

    always_comb begin
        sel = NPC_SEQ;
        if (exc_req)
            sel = NPC_EXC;
        else if (eret)
            sel = NPC_ERET;
        else if (br_taken)
            sel = NPC_BR;
    end

    always_comb begin
        next_pc = pc_out + 32'd4;
        case (sel)
            NPC_EXC:  next_pc = EXC_VECTOR;
            NPC_ERET: next_pc = epc;
            NPC_BR:   next_pc = br_target & ~32'd3;
            default:  next_pc = pc_out + 32'd4;
        endcase
    end

    assign epc_we = exc_req;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/commit controller driving the PC register: imem handshake, instruction
// hold, next-PC selection and the EPC register. All outputs are registered.
module pc_fetch_sequencer
    import cpu31_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = CPU31_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = CPU31_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_out,
    output logic [31:0] pc_in,
    output logic        pc_ena,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic        halt,
    output logic [31:0] epc
);

    state_t      state, state_next;
    logic        req_next, valid_next, ena_next;
    logic        accept, commit, epc_we;
    logic [31:0] next_pc;

    pc_next_sel #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_pc_next_sel (
        .pc_out   (pc_out),
        .epc      (epc),
        .br_target(br_target),
        .exc_req  (exc_req),
        .eret     (eret),
        .br_taken (br_taken),
        .next_pc  (next_pc),
        .epc_we   (epc_we)
    );

    // An ack only counts while our request is visibly high and not halted.
    always_comb begin
        accept = (state == S_FETCH) && imem_req && imem_ack && !halt;
        commit = (state == S_EXEC) && exec_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_BOOT;
        else
            state <= state_next;
    end

    // Registered outputs are computed from the state being entered, so
    // imem_req is already high in the first S_FETCH cycle.
    always_comb begin
        state_next = state;
        req_next   = 1'b0;
        valid_next = 1'b0;
        ena_next   = 1'b0;
        case (state)
            S_BOOT: begin
                state_next = S_FETCH;
                req_next   = !halt;
            end
            S_FETCH: begin
                if (accept) begin
                    state_next = S_EXEC;
                    valid_next = 1'b1;
                end else begin
                    req_next = !halt;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    state_next = S_UPDATE;
                    ena_next   = 1'b1;
                end
            end
            S_UPDATE: begin
                state_next = S_FETCH;
                req_next   = !halt;
            end
            default: state_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_in       <= '0;
            pc_ena      <= 1'b0;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            epc         <= RESET_PC;
        end else begin
            pc_ena      <= ena_next;
            imem_req    <= req_next;
            instr_valid <= valid_next;
            if (accept)
                instr <= imem_rdata;
            if (commit) begin
                pc_in <= next_pc;
                if (epc_we)
                    epc <= pc_out + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed, table-driven bench for pc_fetch_sequencer with hand-written
// sequences for halt and mid-transaction reset.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] pc_in;
    logic        pc_ena;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret;
    logic        halt;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer #(
        .RESET_PC  (32'h0040_0000),
        .EXC_VECTOR(32'h0040_0004)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_out     (pc_out),
        .pc_in      (pc_in),
        .pc_ena     (pc_ena),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .eret       (eret),
        .halt       (halt),
        .epc        (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] target;
        logic [31:0] exp_pc_in;
        logic [31:0] exp_epc;
        logic        exc;
        logic        er;
        logic        br;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc_in"}, pc_in, 32'h0);
        check({tag, "_pc_ena"}, {31'b0, pc_ena}, 32'h0);
        check({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
        check({tag, "_epc"}, epc, 32'h0040_0000);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   n;
        v = vecs[idx];
        pc_out = v.pc;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("v%0d_req_wait", idx), {31'b0, imem_req}, 32'h1);
        // Hold the request one cycle before acking.
        tick();
        check($sformatf("v%0d_req_held", idx), {31'b0, imem_req}, 32'h1);
        check($sformatf("v%0d_no_early_valid", idx), {31'b0, instr_valid}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check($sformatf("v%0d_valid", idx), {31'b0, instr_valid}, 32'h1);
        check($sformatf("v%0d_instr", idx), instr, v.rdata);
        check($sformatf("v%0d_req_drop", idx), {31'b0, imem_req}, 32'h0);
        tick();
        check($sformatf("v%0d_valid_pulse", idx), {31'b0, instr_valid}, 32'h0);
        // Flags without exec_done must not commit.
        exc_req  = 1'b1;
        eret     = 1'b1;
        br_taken = 1'b1;
        tick();
        check($sformatf("v%0d_no_commit", idx), {31'b0, pc_ena}, 32'h0);
        check($sformatf("v%0d_instr_hold", idx), instr, v.rdata);
        exc_req   = v.exc;
        eret      = v.er;
        br_taken  = v.br;
        br_target = v.target;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        exc_req   = 1'b0;
        eret      = 1'b0;
        br_taken  = 1'b0;
        check($sformatf("v%0d_pc_ena", idx), {31'b0, pc_ena}, 32'h1);
        check($sformatf("v%0d_pc_in", idx), pc_in, v.exp_pc_in);
        check($sformatf("v%0d_epc", idx), epc, v.exp_epc);
        tick();
        check($sformatf("v%0d_pc_ena_pulse", idx), {31'b0, pc_ena}, 32'h0);
        check($sformatf("v%0d_req_rise", idx), {31'b0, imem_req}, 32'h1);
        pc_out = v.exp_pc_in;
    endtask

    initial begin
        //         pc            rdata         target        exp_pc_in     exp_epc       exc   eret  br
        vecs[0] = '{32'h00400000, 32'h24010001, 32'h00000000, 32'h00400004, 32'h00400000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00400010, 32'h10000003, 32'h00400043, 32'h00400040, 32'h00400000, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'h00400020, 32'h0000000c, 32'h00000000, 32'h00400004, 32'h00400024, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h00400004, 32'h42000018, 32'h00000000, 32'h00400024, 32'h00400024, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h00400030, 32'h0000000d, 32'h00400100, 32'h00400004, 32'h00400034, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{32'h00400008, 32'h42000018, 32'h00400200, 32'h00400034, 32'h00400034, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00400034, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h00400050, 32'h08100018, 32'h00400063, 32'h00400060, 32'h00400034, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{32'h00400070, 32'h42000018, 32'h00000000, 32'h00400000, 32'h00400000, 1'b0, 1'b1, 1'b0};

        rst        = 1'b1;
        pc_out     = 32'h0040_0000;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        exc_req    = 1'b0;
        eret       = 1'b0;
        halt       = 1'b0;
        #1;
        check_reset_values("rst0");
        tick();
        tick();
        rst = 1'b0;
        check({"boot_req"}, {31'b0, imem_req}, 32'h0);

        for (int i = 0; i < 8; i++)
            run_vec(i);

        // Halt: request drops and a stray ack is ignored for five cycles.
        halt = 1'b1;
        tick();
        check("halt_req_drop", {31'b0, imem_req}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            imem_ack   = (i == 1);
            imem_rdata = 32'hDEADBEEF;
            tick();
            check($sformatf("halt%0d_req", i), {31'b0, imem_req}, 32'h0);
            check($sformatf("halt%0d_valid", i), {31'b0, instr_valid}, 32'h0);
        end
        imem_ack = 1'b0;
        check("halt_instr_hold", instr, 32'h08100018);
        halt = 1'b0;
        tick();
        check("halt_release_req", {31'b0, imem_req}, 32'h1);

        // Reset in S_EXEC with exec_done pending.
        imem_ack   = 1'b1;
        imem_rdata = 32'h11111111;
        tick();
        imem_ack = 1'b0;
        check("rexec_valid", {31'b0, instr_valid}, 32'h1);
        exec_done = 1'b1;
        exc_req   = 1'b1;
        rst       = 1'b1;
        #1;
        check_reset_values("rexec");
        tick();
        check("rexec_no_ena", {31'b0, pc_ena}, 32'h0);
        exec_done = 1'b0;
        exc_req   = 1'b0;
        rst       = 1'b0;
        imem_ack  = 1'b1;
        imem_rdata = 32'h22222222;
        tick();
        check("rexec_boot_ack_ignored", {31'b0, instr_valid}, 32'h0);
        check("rexec_fetch_req", {31'b0, imem_req}, 32'h1);

        // Reset in S_FETCH with an ack arriving during reset and S_BOOT.
        rst = 1'b1;
        #1;
        check_reset_values("rfetch");
        tick();
        check("rfetch_no_valid", {31'b0, instr_valid}, 32'h0);
        rst = 1'b0;
        tick();
        check("rfetch_boot_valid", {31'b0, instr_valid}, 32'h0);
        check("rfetch_instr", instr, 32'h0);
        check("rfetch_req", {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b0;

        run_vec(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
